// File: rtl/cmd_dispatch.sv
// Command dispatcher: takes one UART command at a time, routes it to a target,
// waits for completion or timeout, and returns a one-byte status over the UART.
module cmd_dispatch #(
  parameter int unsigned NUM_TGT  = 4,
  parameter int unsigned TIMEOUT  = 50000,
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter logic [7:0]  NAK_BYTE = 8'hEE,
  parameter logic [7:0]  TO_BYTE  = 8'hEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rdy,
  input  logic [23:0]        cmd,
  output logic               clr_cmd_rdy,
  output logic               trmt,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic [NUM_TGT-1:0] tgt_vld,
  output logic [3:0]         tgt_op,
  output logic [15:0]        tgt_data,
  input  logic [NUM_TGT-1:0] tgt_ack,
  input  logic [NUM_TGT-1:0] tgt_err,
  output logic               busy,
  output logic [7:0]         cmd_cnt,
  output logic [7:0]         nak_cnt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    ISSUE   = 3'd2,
    RESP    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [23:0]        cmd_q;
  logic [3:0]         idx;
  logic               idx_ok;
  logic [NUM_TGT-1:0] sel;
  logic               hit_ack;
  logic               hit_err;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               tx_done_q;
  logic               tx_rise;
  logic [7:0]         tx_data_d;
  logic               resp_is_nak;

  assign idx         = cmd_q[23:20];
  assign idx_ok      = (32'(idx) < NUM_TGT);
  assign hit_ack     = |(tgt_ack & sel);
  assign hit_err     = |(tgt_err & sel);
  assign cnt_last    = (cnt == CNT_LAST);
  assign tx_rise     = tx_done & ~tx_done_q;
  assign resp_is_nak = (tx_data == NAK_BYTE) || (tx_data == TO_BYTE);
  assign tgt_op      = cmd_q[19:16];
  assign tgt_data    = cmd_q[15:0];

  // One-hot decode of the latched target index; out-of-range index selects nothing.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      sel[i] = (32'(idx) == i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and the response byte chosen on the way into RESP.
  always_comb begin
    state_d   = state;
    tx_data_d = tx_data;
    case (state)
      IDLE: begin
        if (cmd_rdy) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (idx_ok) begin
          state_d = ISSUE;
        end else begin
          state_d   = RESP;
          tx_data_d = NAK_BYTE;
        end
      end
      ISSUE: begin
        // Error outranks ack, and any completion outranks the timeout.
        if (hit_err) begin
          state_d   = RESP;
          tx_data_d = NAK_BYTE;
        end else if (hit_ack) begin
          state_d   = RESP;
          tx_data_d = ACK_BYTE;
        end else if (cnt_last) begin
          state_d   = RESP;
          tx_data_d = TO_BYTE;
        end
      end
      RESP: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_rise) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch: captured only when a command is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else if ((state == IDLE) && cmd_rdy) begin
      cmd_q <= cmd;
    end
  end

  // ISSUE cycle counter; held at zero outside ISSUE so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Transmitter done history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
    end
  end

  // Registered control outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cmd_rdy <= 1'b0;
      trmt        <= 1'b0;
      tgt_vld     <= '0;
      busy        <= 1'b0;
      tx_data     <= '0;
    end else begin
      clr_cmd_rdy <= (state_d == LATCH);
      trmt        <= (state_d == RESP);
      tgt_vld     <= (state_d == ISSUE) ? sel : '0;
      busy        <= (state_d != IDLE);
      tx_data     <= tx_data_d;
    end
  end

  // Completion statistics, updated when the response byte has gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt <= '0;
      nak_cnt <= '0;
    end else if ((state == WAIT_TX) && tx_rise) begin
      cmd_cnt <= cmd_cnt + 8'd1;
      if (resp_is_nak && (nak_cnt != 8'hFF)) begin
        nak_cnt <= nak_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: vector table plus corner-case sequences.
module tb_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_rdy;
  logic [23:0] cmd;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [3:0]  tgt_vld;
  logic [3:0]  tgt_op;
  logic [15:0] tgt_data;
  logic [3:0]  tgt_ack;
  logic [3:0]  tgt_err;
  logic        busy;
  logic [7:0]  cmd_cnt;
  logic [7:0]  nak_cnt;

  cmd_dispatch #(
    .NUM_TGT (4),
    .TIMEOUT (16),
    .ACK_BYTE(8'hA5),
    .NAK_BYTE(8'hEE),
    .TO_BYTE (8'hEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .clr_cmd_rdy(clr_cmd_rdy),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tgt_vld    (tgt_vld),
    .tgt_op     (tgt_op),
    .tgt_data   (tgt_data),
    .tgt_ack    (tgt_ack),
    .tgt_err    (tgt_err),
    .busy       (busy),
    .cmd_cnt    (cmd_cnt),
    .nak_cnt    (nak_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] cmd;
    logic [3:0]  ack;
    logic [3:0]  err;
    int          delay;
    logic [7:0]  exp_byte;
    int          exp_vld;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         vld_total = 0;
  int         clr_total = 0;
  int         trmt_total = 0;
  int         v0, c0, t0;
  logic [7:0] m_cmd = 8'd0;
  logic [7:0] m_nak = 8'd0;
  vec_t       vecs[9];

  function automatic vec_t mk(input string nm, input logic [23:0] c, input logic [3:0] a,
                              input logic [3:0] e, input int d, input logic [7:0] b, input int nv);
    vec_t v;
    v.name = nm; v.cmd = c; v.ack = a; v.err = e; v.delay = d; v.exp_byte = b; v.exp_vld = nv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DUT produced in that cycle.
  task tick();
    @(negedge clk);
    if (trmt) begin
      obs_q.push_back(tx_data);
      trmt_total++;
    end
    if (|tgt_vld) vld_total++;
    if (clr_cmd_rdy) clr_total++;
  endtask

  // Present a command, play the target side, and score the response byte at trmt.
  task automatic issue_part(input vec_t v);
    int         n;
    logic [3:0] oh;
    logic [7:0] o;
    logic [7:0] e;
    exp_q.push_back(v.exp_byte);
    v0 = vld_total; c0 = clr_total; t0 = trmt_total;
    cmd = v.cmd;
    cmd_rdy = 1'b1;
    tick();
    n = 1;
    while (!clr_cmd_rdy && n < 20) begin tick(); n++; end
    chk({v.name, "_clr_seen"}, 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    if (v.exp_vld > 0) begin
      n = 0;
      while (tgt_vld == 4'd0 && n < 10) begin tick(); n++; end
      oh = 4'b0001;
      oh = oh << v.cmd[23:20];
      chk({v.name, "_vld_onehot"}, 32'(tgt_vld), 32'(oh));
      chk({v.name, "_op"}, 32'(tgt_op), 32'(v.cmd[19:16]));
      chk({v.name, "_data"}, 32'(tgt_data), 32'(v.cmd[15:0]));
    end
    if ((v.ack | v.err) != 4'd0) begin
      repeat (v.delay) tick();
      tgt_ack = v.ack;
      tgt_err = v.err;
      tick();
      tgt_ack = 4'd0;
      tgt_err = 4'd0;
    end
    n = 0;
    while (!trmt && n < 100) begin tick(); n++; end
    chk({v.name, "_trmt_seen"}, 32'(trmt), 32'd1);
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_txdata actual=none expected=%0h", v.name, e);
    end else begin
      o = obs_q.pop_front();
      chk({v.name, "_txdata"}, 32'(o), 32'(e));
    end
  endtask

  // Finish the transmit handshake and compare counters against the model.
  task automatic finish_part(input vec_t v);
    int n;
    tx_done = 1'b0;
    tick();
    tick();
    chk({v.name, "_busy_wait_tx"}, 32'(busy), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    chk({v.name, "_idle_after_tx"}, 32'(busy), 32'd0);
    m_cmd = m_cmd + 8'd1;
    if (v.exp_byte != 8'hA5 && m_nak != 8'hFF) m_nak = m_nak + 8'd1;
    chk({v.name, "_cmd_cnt"}, 32'(cmd_cnt), 32'(m_cmd));
    chk({v.name, "_nak_cnt"}, 32'(nak_cnt), 32'(m_nak));
    chk({v.name, "_vld_cycles"}, 32'(vld_total - v0), 32'(v.exp_vld));
    chk({v.name, "_clr_pulses"}, 32'(clr_total - c0), 32'd1);
    chk({v.name, "_trmt_pulses"}, 32'(trmt_total - t0), 32'd1);
  endtask

  task automatic do_cmd(input vec_t v);
    issue_part(v);
    finish_part(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t va;
    vec_t vb;
    int   n;

    vecs[0] = mk("ack_tgt1",  24'h13BEEF, 4'b0010, 4'b0000,  5, 8'hA5,  6);
    vecs[1] = mk("illegal7",  24'h700000, 4'b0000, 4'b0000,  0, 8'hEE,  0);
    vecs[2] = mk("ack_err2",  24'h251234, 4'b0100, 4'b0100,  1, 8'hEE,  2);
    vecs[3] = mk("wrong_tgt", 24'h210F0F, 4'b0001, 4'b0000,  2, 8'hEF, 16);
    vecs[4] = mk("timeout0",  24'h09AAAA, 4'b0000, 4'b0000,  0, 8'hEF, 16);
    vecs[5] = mk("ack_cnt0",  24'h3F5555, 4'b1000, 4'b0000,  0, 8'hA5,  1);
    vecs[6] = mk("err_last",  24'h020001, 4'b0000, 4'b0001, 15, 8'hEE, 16);
    vecs[7] = mk("ack_last",  24'h14FFFF, 4'b0010, 4'b0000, 15, 8'hA5, 16);
    vecs[8] = mk("illegalF",  24'hF00000, 4'b0000, 4'b0000,  0, 8'hEE,  0);

    rst = 1'b1; cmd_rdy = 1'b0; cmd = 24'd0; tx_done = 1'b0; tgt_ack = 4'd0; tgt_err = 4'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
    chk("rst_vld", 32'(tgt_vld), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_op_data", {12'd0, tgt_op, tgt_data}, 32'd0);
    chk("rst_cnts", {16'd0, cmd_cnt, nak_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) do_cmd(vecs[i]);

    // Second command arrives during WAIT_TX; tx_done is stale-high from before trmt.
    va = mk("stale_a", 24'h111111, 4'b0010, 4'b0000, 0, 8'hA5, 1);
    vb = mk("queued_b", 24'h022222, 4'b0000, 4'b0001, 0, 8'hEE, 1);
    tx_done = 1'b1;
    tick();
    issue_part(va);
    cmd = vb.cmd;
    cmd_rdy = 1'b1;
    n = clr_total;
    repeat (6) tick();
    chk("busy_no_clr", 32'(clr_total - n), 32'd0);
    chk("stale_txdone_busy", 32'(busy), 32'd1);
    finish_part(va);
    do_cmd(vb);

    // Reset while a command is in ISSUE.
    cmd = 24'h101234;
    cmd_rdy = 1'b1;
    n = 0;
    tick();
    while (!clr_cmd_rdy && n < 20) begin tick(); n++; end
    cmd_rdy = 1'b0;
    n = 0;
    while (tgt_vld == 4'd0 && n < 10) begin tick(); n++; end
    chk("pre_rst_vld", 32'(tgt_vld), 32'h2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vld", 32'(tgt_vld), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_trmt", 32'(trmt), 32'd0);
    chk("midrst_cnts", {16'd0, cmd_cnt, nak_cnt}, 32'd0);
    chk("midrst_txdata", 32'(tx_data), 32'd0);
    m_cmd = 8'd0;
    m_nak = 8'd0;
    n = trmt_total;
    repeat (20) tick();
    chk("midrst_no_trmt", 32'(trmt_total - n), 32'd0);
    chk("midrst_still_idle", 32'(busy), 32'd0);
    do_cmd(mk("post_rst", 24'h3C00AA, 4'b1000, 4'b0000, 2, 8'hA5, 3));

    // Drive nak_cnt into saturation and cmd_cnt through its wrap.
    for (int k = 0; k < 260; k++) do_cmd(mk("sat", 24'h800000, 4'b0000, 4'b0000, 0, 8'hEE, 0));
    do_cmd(mk("after_sat", 24'h2A0101, 4'b0100, 4'b0000, 3, 8'hA5, 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
